// File: rtl/axi4_lite_master_arbiter.sv
// axi4_lite_master_arbiter: round-robin AXI4-Lite master-port scheduler with independent read/write channels and watchdog
module axi4_lite_master_arbiter_ch #(
  parameter int N = 2,
  parameter int T = 256,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout
);
  localparam int CNT_W = T > 1 ? $clog2(T) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(T > 0 ? T - 1 : 0);
  localparam logic [N-1:0] ONE = N'(1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_n;
  logic [N-1:0] grant_n;
  logic [IDX_W-1:0] idx_n, ptr, ptr_n, win;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic busy_n, to_n, found, expire;
  function automatic logic [IDX_W-1:0] wrap(input int v);
    return IDX_W'(v % N);
  endfunction
  assign expire = (T != 0) && (cnt == LIMIT);
  // first requester at or circularly above the round-robin pointer
  always_comb begin
    win = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[wrap(int'(ptr) + i)]) begin
        found = 1'b1;
        win = wrap(int'(ptr) + i);
      end
    end
  end
  // next state: grant from IDLE, hold until done or watchdog release
  always_comb begin
    state_n = state;
    grant_n = grant;
    idx_n = grant_idx;
    busy_n = busy;
    to_n = 1'b0;
    ptr_n = ptr;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (|req) begin
        state_n = GRANT;
        grant_n = ONE << win;
        idx_n = win;
        busy_n = 1'b1;
        cnt_n = '0;
      end
    end else begin
      cnt_n = &cnt ? cnt : cnt + 1'b1;
      if (done || expire) begin
        state_n = IDLE;
        grant_n = '0;
        busy_n = 1'b0;
        ptr_n = wrap(int'(grant_idx) + 1);
        to_n = !done;
      end
    end
  end
  // registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_idx <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      grant_idx <= idx_n;
      busy <= busy_n;
      timeout <= to_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
    end
  end
endmodule

module axi4_lite_master_arbiter #(
  parameter int MASTER_NUM = 2,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int IDX_W = MASTER_NUM > 1 ? $clog2(MASTER_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [MASTER_NUM-1:0] wr_req,
  input  logic                  wr_done,
  output logic [MASTER_NUM-1:0] wr_grant,
  output logic [IDX_W-1:0]      wr_grant_idx,
  output logic                  wr_busy,
  output logic                  wr_timeout,
  input  logic [MASTER_NUM-1:0] rd_req,
  input  logic                  rd_done,
  output logic [MASTER_NUM-1:0] rd_grant,
  output logic [IDX_W-1:0]      rd_grant_idx,
  output logic                  rd_busy,
  output logic                  rd_timeout
);
  axi4_lite_master_arbiter_ch #(.N(MASTER_NUM), .T(TIMEOUT_CYCLES), .IDX_W(IDX_W)) u_wr (
    .clk(clk), .rst(rst), .req(wr_req), .done(wr_done),
    .grant(wr_grant), .grant_idx(wr_grant_idx), .busy(wr_busy), .timeout(wr_timeout)
  );
  axi4_lite_master_arbiter_ch #(.N(MASTER_NUM), .T(TIMEOUT_CYCLES), .IDX_W(IDX_W)) u_rd (
    .clk(clk), .rst(rst), .req(rd_req), .done(rd_done),
    .grant(rd_grant), .grant_idx(rd_grant_idx), .busy(rd_busy), .timeout(rd_timeout)
  );
endmodule

// File: doc/axi4_lite_master_arbiter.md
Name: axi4_lite_master_arbiter

Overview:
- Round-robin scheduler that shares the single AXI4-Lite interconnect master port between MASTER_NUM requesters, e.g. CPU instruction, CPU data and debug.
- Write and read paths arbitrate independently.
- Each grant is held until that transaction's response handshake completes, or until a watchdog timeout expires.
- Outputs drive the interconnect's master-side muxes. The address decoder downstream then routes the granted transaction to a slave.

Parameters:
- MASTER_NUM, 2, number of requesting masters (>=2).
- TIMEOUT_CYCLES, 256, max cycles a grant is held without a response. 0 disables the watchdog.
- IDX_W, (MASTER_NUM>1 ? $clog2(MASTER_NUM) : 1), width of grant index (derived, not overridden).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_req  input  MASTER_NUM  per-master write request: AWVALID|WVALID of that master.
- wr_done  input  1  write response handshake complete (BVALID&BREADY on the shared port).
- wr_grant  output  MASTER_NUM  one-hot write grant.
- wr_grant_idx  output  IDX_W  index of the granted write master.
- wr_busy  output  1  write grant active.
- wr_timeout  output  1  one-cycle pulse when the write watchdog releases a grant.
- rd_req  input  MASTER_NUM  per-master read request: ARVALID.
- rd_done  input  1  read data handshake complete (RVALID&RREADY).
- rd_grant  output  MASTER_NUM  one-hot read grant.
- rd_grant_idx  output  IDX_W  index of the granted read master.
- rd_busy  output  1  read grant active.
- rd_timeout  output  1  one-cycle pulse when the read watchdog releases a grant.

Behaviour:
- The read and write channels are identical, independent instances of the logic below. They share nothing.
- FSM per channel: IDLE, GRANT.
- Reset: state IDLE, grant=0, grant_idx=0, busy=0, timeout=0, rr pointer=0, watchdog counter=0.
- All outputs are registered. No combinational path from req/done to any output.

IDLE:
- If req!=0, select the first set bit searching circularly from the rr pointer upward, wrapping MASTER_NUM-1 -> 0.
- Next cycle: state GRANT, grant=one-hot(winner), grant_idx=winner, busy=1, counter=0.
- Latency is 1 cycle from req to grant.
- If req==0, stay in IDLE.

GRANT:
- Grant is frozen. Changes on req, including deassertion by the granted master, are ignored.
- Counter increments each cycle.
- done=1: next cycle is IDLE, grant=0, busy=0, rr pointer=(grant_idx+1) mod MASTER_NUM.
- Watchdog: TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1 with done=0. Next cycle is IDLE, grant=0, pointer advances as above, and timeout=1 for exactly that cycle.
- done and watchdog expiry in the same cycle: done wins, no timeout pulse.
- Counter saturates and never wraps. The watchdog fires exactly TIMEOUT_CYCLES cycles after grant asserts.

Other timing rules:
- done while IDLE is ignored.
- One IDLE cycle always separates consecutive grants. The earliest re-grant is 2 cycles after the done cycle.
- Single requester continuously asserting: grant, release, re-grant cycle repeats. No starvation.
- Fairness: with all requesters asserted, grants rotate 0,1,...,MASTER_NUM-1,0.
- rst asserted mid-transaction: next cycle all outputs return to reset values, regardless of pending done.

Test Plan (MASTER_NUM=3, TIMEOUT_CYCLES=8 unless stated):
- Reset, then wr_req=3'b100 at cycle 0 -> wr_grant=3'b100, wr_grant_idx=2, wr_busy=1 at cycle 1. wr_done at cycle 5 -> wr_grant=0 at cycle 6.
- rd_req=3'b111 held for 6 grants, each with rd_done 2 cycles after grant -> grant index order 0,1,2,0,1,2, one idle cycle between grants.
- Write grant to master 1, wr_req drops to 0 the next cycle, no wr_done -> grant held 8 cycles. wr_timeout=1 for 1 cycle as wr_grant clears. Next wr_req=3'b011 grants master 0 (pointer=2 wraps, first set bit from 2 circularly is 0).
- wr_done and watchdog expiry coincide (done on cycle 8 of grant) -> grant clears, wr_timeout stays 0.
- Write and read simultaneous: wr_req=3'b001, rd_req=3'b010 -> wr_grant=3'b001 and rd_grant=3'b010 both at cycle 1. Completing the read does not affect the write grant.
- rst pulsed while rd_busy=1 -> next cycle rd_grant=0, rd_busy=0. Subsequent rd_req=3'b110 grants master 1 (pointer reset to 0).
- TIMEOUT_CYCLES=0: a grant held 1000 cycles without rd_done -> no release, rd_timeout never asserts.
